// File: rtl/cache_tester_gen.sv
// cache_tester_gen: cache stimulus/check engine.
// Writes an address-derived pattern to N line addresses, reads them back,
// compares each returned line, then issues one flush request.
// Address modes: sequential, strided, 16-bit LFSR.
// Optional macro CACHE_TESTER_ERRLOG_EN adds err_cnt and first_err_addr outputs.
module cache_tester_gen #(
    parameter int ADDR_W    = 36,
    parameter int DATA_W    = 128,
    parameter int LINE_LOG2 = 4,
    parameter int OPS_LOG2  = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic [1:0]          cfg_mode,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [15:0]         cfg_stride,
    input  logic [31:0]         cfg_seed,
    input  logic [OPS_LOG2:0]   cfg_num_ops,
    input  logic [1:0]          cfg_wtype,
    input  logic                mem_stall_in,
    input  logic                cache_rd_valid,
    input  logic [DATA_W-1:0]   cache_data,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                r,
    output logic                w,
    output logic [1:0]          w_type,
    output logic [1:0]          flushtype,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef CACHE_TESTER_ERRLOG_EN
    ,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr
`endif
);

    localparam int OFF_W  = ADDR_W - LINE_LOG2;
    localparam int NWORDS = DATA_W / 32;
    localparam logic [OPS_LOG2:0] IDX_ONE = 1;
    localparam logic [15:0] LFSR_MASK = (OPS_LOG2 >= 16) ? 16'hFFFF
                                      : 16'((32'd1 << OPS_LOG2) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_FLUSH, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic                r_go_d;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_base;
    logic [15:0]         r_stride;
    logic [31:0]         r_seed;
    logic [OPS_LOG2:0]   r_num_ops;
    logic [OPS_LOG2:0]   r_idx;
    logic [1:0]          r_wtype;
    logic [15:0]         r_lfsr;
    logic                r_err;

    logic                w_start;
    logic                w_last;
    logic [15:0]         w_lfsr_step;
    logic [OFF_W-1:0]    w_off;
    logic [ADDR_W-1:0]   w_addr_sum;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_addr32;
    logic [DATA_W-1:0]   w_pattern;
    logic                w_mismatch;

    // A zero seed would lock the LFSR at zero forever.
    function automatic logic [15:0] seed_lfsr(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    assign w_start     = (r_state == S_IDLE) && go && !r_go_d;
    assign w_last      = (r_idx == (r_num_ops - IDX_ONE));
    // Fibonacci LFSR, taps 16,14,13,11.
    assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Line offset for the current op, selected by the latched address mode.
    always_comb begin
        case (r_mode)
            2'd1:    w_off = OFF_W'(r_idx) * OFF_W'(r_stride);
            2'd2:    w_off = OFF_W'(r_lfsr & LFSR_MASK);
            default: w_off = OFF_W'(r_idx);
        endcase
    end

    assign w_addr_sum = r_base + {w_off, {LINE_LOG2{1'b0}}};
    assign w_addr     = {w_addr_sum[ADDR_W-1:LINE_LOG2], {LINE_LOG2{1'b0}}};
    assign w_addr32   = 32'(w_addr);

    for (genvar k = 0; k < NWORDS; k++) begin : g_pat
        assign w_pattern[32*k +: 32] = w_addr32 ^ r_seed ^ 32'(k);
    end

    assign w_mismatch = (cache_data != w_pattern);
    assign err        = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and request-port outputs; outputs are zero outside the states that drive them.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        w_next    = r_state;
        addr      = '0;
        wr_data   = '0;
        r         = 1'b0;
        w         = 1'b0;
        w_type    = 2'b00;
        flushtype = 2'b00;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start) w_next = (cfg_num_ops == '0) ? S_FLUSH : S_WRITE;
            end
            S_WRITE: begin
                w       = 1'b1;
                w_type  = r_wtype;
                addr    = w_addr;
                wr_data = w_pattern;
                if (!mem_stall_in && w_last) w_next = S_READ;
            end
            S_READ: begin
                r    = 1'b1;
                addr = w_addr;
                if (!mem_stall_in) w_next = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                addr = w_addr;
                if (cache_rd_valid) w_next = w_last ? S_FLUSH : S_READ;
            end
            S_FLUSH: begin
                flushtype = 2'b11;
                if (!mem_stall_in) w_next = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!go) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Run configuration, op index, LFSR and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go_d    <= 1'b0;
            r_mode    <= 2'b00;
            r_base    <= '0;
            r_stride  <= '0;
            r_seed    <= '0;
            r_num_ops <= '0;
            r_wtype   <= 2'b00;
            r_idx     <= '0;
            r_lfsr    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_go_d <= go;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mode    <= cfg_mode;
                        r_base    <= cfg_base;
                        r_stride  <= cfg_stride;
                        r_seed    <= cfg_seed;
                        r_num_ops <= cfg_num_ops;
                        r_wtype   <= cfg_wtype;
                        r_idx     <= '0;
                        r_err     <= 1'b0;
                        r_lfsr    <= seed_lfsr(cfg_seed[15:0]);
                    end
                end
                S_WRITE: begin
                    if (!mem_stall_in) begin
                        if (w_last) begin
                            // Read phase replays the exact address sequence of the write phase.
                            r_idx  <= '0;
                            r_lfsr <= seed_lfsr(r_seed[15:0]);
                        end else begin
                            r_idx  <= r_idx + IDX_ONE;
                            r_lfsr <= w_lfsr_step;
                        end
                    end
                end
                S_WAIT_RD: begin
                    // Address is held through WAIT_RD, so the LFSR advances on completion, not on accept.
                    if (cache_rd_valid) begin
                        if (w_mismatch) r_err <= 1'b1;
                        if (!w_last) begin
                            r_idx  <= r_idx + IDX_ONE;
                            r_lfsr <= w_lfsr_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_TESTER_ERRLOG_EN
    logic [15:0]       r_err_cnt;
    logic [ADDR_W-1:0] r_first_err_addr;

    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;

    // Saturating mismatch counter and address of the first mismatch in the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
        end else if (w_start) begin
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
        end else if ((r_state == S_WAIT_RD) && cache_rd_valid && w_mismatch) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            if (!r_err) r_first_err_addr <= w_addr;
        end
    end
`endif

endmodule

// File: doc/cache_tester_gen.md
Name: cache_tester_gen

Overview:
- Parametrised cache stimulus/check engine for the cache test bench; drives the cache CPU-side request port.
- Runs a write phase over N line addresses, then a read-back phase over the same addresses, checking returned lines against a deterministic address-derived pattern.
- Finishes with a flush request.
- Supports sequential, strided and pseudo-random (LFSR) address modes, honours the cache stall handshake, and reports pass/fail.

Parameters:
- ADDR_W, 36, byte address width.
- DATA_W, 128, cache line width in bits; multiple of 32.
- LINE_LOG2, 4, log2 of line size in bytes; address low bits forced to zero.
- OPS_LOG2, 14, width of the op index; max ops per phase = 2^OPS_LOG2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  level; rising-edge sampling in IDLE starts a run; low in DONE returns to IDLE.
- cfg_mode  in  2  0=SEQ, 1=STRIDE, 2=LFSR, 3=reserved (treated as SEQ).
- cfg_base  in  ADDR_W  base byte address.
- cfg_stride  in  16  line stride for STRIDE mode.
- cfg_seed  in  32  data seed; low 16 bits also seed the LFSR.
- cfg_num_ops  in  OPS_LOG2+1  ops per phase; 0 = go straight to flush.
- cfg_wtype  in  2  w_type value driven on writes.
- mem_stall_in  in  1  cache stall; a request is accepted in any cycle it is low.
- cache_rd_valid  in  1  read data valid pulse.
- cache_data  in  DATA_W  read data.
- addr  out  ADDR_W  request address.
- wr_data  out  DATA_W  write data.
- r  out  1  read request.
- w  out  1  write request.
- w_type  out  2  write type.
- flushtype  out  2  2'b11 during flush request, else 0.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  high in DONE.
- err  out  1  sticky mismatch flag, cleared at run start.

Behaviour:
- Reset (async, rst_n low): state=IDLE. All of the following are 0: outputs, index, LFSR, err.
- IDLE:
  - On go=1 with the previous-cycle go=0, latch all cfg_* inputs, clear err, and set index i=0.
  - Load the LFSR with cfg_seed[15:0]; a zero seed is replaced by 16'h0001.
  - Next state = WRITE, or FLUSH if cfg_num_ops==0.
- Address for op i:
  - off = i (SEQ); i*stride truncated to ADDR_W-LINE_LOG2 (STRIDE); LFSR state masked to OPS_LOG2 bits (LFSR).
  - addr = cfg_base + (off << LINE_LOG2), wraps mod 2^ADDR_W; low LINE_LOG2 bits forced to 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per accepted op. Reloaded from the seed at the WRITE->READ transition so both phases visit the identical sequence.
- Pattern: 32-bit word k of the line (k=0 is LSW) = addr[31:0] ^ cfg_seed ^ k; addr is zero-extended if ADDR_W<32.
- WRITE:
  - Drive w=1, w_type=cfg_wtype, wr_data=pattern(addr).
  - While mem_stall_in=1, addr/wr_data/w stay stable.
  - On acceptance, i++. After the op with i==cfg_num_ops-1 is accepted: i=0, LFSR reload, go to READ.
- READ:
  - Drive r=1 (w=0, w_type=0).
  - On acceptance go to WAIT_RD; r drops next cycle and addr holds.
- WAIT_RD:
  - Wait any number of cycles for cache_rd_valid; it is ignored in all other states.
  - On valid, compare cache_data with pattern(addr); mismatch sets err.
  - Then i++ and go to READ, or FLUSH if this was the last op.
- FLUSH: flushtype=2'b11 held until a cycle with mem_stall_in=0, then DONE.
- DONE:
  - done=1; err and the ERRLOG outputs hold.
  - On go=0 go to IDLE, and done falls the same cycle the state changes.
- go going low during WRITE/READ/WAIT_RD does not abort the run. Only reset aborts.
- Latency: first request is driven the cycle after go is sampled high in IDLE. Back-to-back writes run at one per cycle with no stall; each read takes at least 2 cycles.
- Simultaneous stall and rd_valid in WAIT_RD: rd_valid is consumed; stall is irrelevant there.
- Max run: cfg_num_ops = 2^OPS_LOG2 (all ones + 1) is legal; the index compare uses the OPS_LOG2+1 width.

Optional Feature:
- CACHE_TESTER_ERRLOG_EN defined: adds outputs err_cnt[15:0] and first_err_addr[ADDR_W-1:0], both cleared at run start.
  - err_cnt increments per mismatch and saturates at 16'hFFFF.
  - first_err_addr captures the address of the first mismatch.
- Undefined: these ports and registers do not exist; only the sticky err is reported.

Test Plan:
- SEQ, base=0x100, num_ops=4, seed=0, model returns written data, no stall:
  - writes to 0x100,0x110,0x120,0x130 on consecutive cycles, word0 of first = 0x100.
  - then 4 reads, flushtype=11 once, done=1, err=0.
- STRIDE=3, base=0, num_ops=3 -> write/read addresses 0x000,0x030,0x060.
- LFSR, seed=0 -> LFSR uses 0x0001; the read address sequence equals the write sequence exactly.
- Random mem_stall_in at 50% plus rd_valid delays of 0-5 cycles:
  - addr/wr_data stay stable while stalled.
  - no op lost or duplicated; exactly num_ops writes and num_ops reads.
- Model corrupts one bit of the read at 0x120:
  - err=1 at DONE.
  - with ERRLOG: err_cnt=1, first_err_addr=0x120.
- rst_n asserted in WAIT_RD -> all outputs 0 immediately; the next go starts a clean run with err=0.
- num_ops=0 -> IDLE -> FLUSH -> DONE with no r/w pulses.
